// File: rtl/shiftreg_sequencer.sv
// shiftreg_sequencer: sequences one load / WIDTH-shift / capture transfer of the parallel-load shift register
module shiftreg_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [WIDTH-1:0] sr_pout,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_pdata,
    output logic             sr_shift,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);
    localparam int DW = $clog2(DIV) + 1;
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

    state_t        state, state_d;
    logic [DW-1:0] div_cnt, div_d;
    logic [BW-1:0] bit_cnt, bit_d;
    logic          tick;

    assign busy = state != IDLE;

    // abort suppresses strobes combinationally and sends every busy state home
    always_comb begin
        tick     = state == SHIFT && div_cnt == DW'(DIV - 1);
        state_d  = state;
        div_d    = '0;
        bit_d    = '0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        if (state == IDLE)
            state_d = start ? LOAD : IDLE;
        else if (abort)
            state_d = IDLE;
        else
            case (state)
                LOAD: begin
                    sr_load = 1'b1;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sr_shift = tick;
                    div_d    = tick ? '0 : div_cnt + DW'(1);
                    bit_d    = bit_cnt + BW'(tick);
                    state_d  = (tick && bit_cnt == BW'(WIDTH - 1)) ? FINISH : SHIFT;
                end
                default: state_d = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sr_pdata <= '0;
            rx_data  <= '0;
            done     <= 1'b0;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            done    <= state == FINISH && !abort;
            if (state == IDLE && start)
                sr_pdata <= tx_data;
            if (state == FINISH && !abort)
                rx_data <= sr_pout;
        end
    end
endmodule

// File: tb/tb_shiftreg_sequencer.sv
// tb_shiftreg_sequencer: directed vectors against a behavioural shift register, DIV=4 and DIV=1 instances
module tb_shiftreg_sequencer;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, start1 = 1'b0, lb = 1'b0;
    logic [W-1:0] tx_data = '0, tx1 = '0, pout, pout1, pdata, pdata1, rx, rx1;
    logic         load, shift, busy, done, load1, shift1, busy1, done1;
    logic [W-1:0] sr = '0, sr1 = '0;
    int           n_chk = 0, n_fail = 0;

    typedef struct {
        logic [W-1:0] tx;
        logic         lb;
        logic [W-1:0] erx;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) sr <= pdata;
        else if (shift) sr <= {sr[W-2:0], lb & sr[W-1]};
        if (load1) sr1 <= pdata1;
        else if (shift1) sr1 <= {sr1[W-2:0], 1'b0};
    end
    assign pout  = sr;
    assign pout1 = sr1;

    shiftreg_sequencer #(.WIDTH(W), .DIV(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tx_data(tx_data), .sr_pout(pout),
        .sr_load(load), .sr_pdata(pdata), .sr_shift(shift), .busy(busy), .done(done), .rx_data(rx)
    );

    shiftreg_sequencer #(.WIDTH(W), .DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .tx_data(tx1), .sr_pout(pout1),
        .sr_load(load1), .sr_pdata(pdata1), .sr_shift(shift1), .busy(busy1), .done(done1), .rx_data(rx1)
    );

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // {sr_load, sr_shift, busy, done} for cycle c of a transfer accepted at the end of cycle 0
    function automatic logic [3:0] expv(input int c, input int d);
        return {c == 1, c >= 1 + d && c <= 1 + W * d && (c - 1) % d == 0, c >= 1 && c <= 2 + W * d, c == 3 + W * d};
    endfunction

    task automatic xfer(input logic [W-1:0] tx, input logic l, input logic [W-1:0] erx,
                        input bit started, input bit noisy, input bit chain, input logic [W-1:0] ctx);
        logic [3:0] e;
        if (!started) begin
            tx_data = tx;
            start   = 1'b1;
            cyc();
        end
        start = 1'b0;
        lb    = l;
        for (int c = 1; c <= 3 + W * D; c++) begin
            start   = (noisy && (c == 10 || c == 20)) || (chain && c == 3 + W * D);
            tx_data = (chain && c == 3 + W * D) ? ctx : noisy ? ~tx : tx;
            @(negedge clk);
            e = expv(c, D);
            chk("sr_load", c, load, e[3]);
            chk("sr_shift", c, shift, e[2]);
            chk("busy", c, busy, e[1]);
            chk("done", c, done, e[0]);
            chk("sr_pdata", c, pdata, tx);
            if (c == 3 + W * D) chk("rx_data", c, rx, erx);
            cyc();
        end
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'hFF, 1'b0, 8'h00};
        vecs[2] = '{8'h01, 1'b0, 8'h00};
        vecs[3] = '{8'h81, 1'b1, 8'h81};
        // reset state, start held during reset
        start   = 1'b1;
        tx_data = 8'hAA;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst load", 0, {load, load1}, 0);
        chk("rst shift", 0, {shift, shift1}, 0);
        chk("rst busy", 0, {busy, busy1}, 0);
        chk("rst done", 0, {done, done1}, 0);
        chk("rst rx", 0, {rx, rx1}, 0);
        chk("rst pdata", 0, {pdata, pdata1}, 0);
        cyc();
        rst_n = 1'b1;
        start = 1'b0;
        cyc();
        @(negedge clk);
        chk("post-rst busy", 0, busy, 0);
        cyc();
        // DIV=1, no loopback
        tx1    = 8'hFF;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            e = expv(c, 1);
            chk("div1 sr_load", c, load1, e[3]);
            chk("div1 sr_shift", c, shift1, e[2]);
            chk("div1 busy", c, busy1, e[1]);
            chk("div1 done", c, done1, e[0]);
            if (c == 11) chk("div1 rx_data", c, rx1, 8'h00);
            cyc();
        end
        foreach (vecs[i]) xfer(vecs[i].tx, vecs[i].lb, vecs[i].erx, 1'b0, 1'b0, 1'b0, '0);
        // starts while busy ignored, then back-to-back start in the done cycle
        xfer(8'hC3, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h3C);
        xfer(8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, '0);
        // abort in SHIFT at cycle 15
        tx_data = 8'h5A;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            abort = c == 15;
            @(negedge clk);
            chk("abort busy", c, busy, c <= 15);
            chk("abort done", c, done, 0);
            chk("abort rx", c, rx, 8'h3C);
            if (c >= 15) chk("abort strobes", c, {load, shift}, 0);
            cyc();
        end
        abort = 1'b0;
        xfer(8'h66, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, '0);
        // abort in LOAD suppresses sr_load
        tx_data = 8'hE7;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        chk("abort-load sr_load", 1, load, 0);
        chk("abort-load busy", 1, busy, 1);
        chk("abort-load pdata", 1, pdata, 8'hE7);
        cyc();
        abort = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk("abort-load idle", c, {busy, shift, done}, 0);
            chk("abort-load rx", c, rx, 8'h66);
            cyc();
        end
        // abort and start together while busy: abort wins
        tx_data = 8'h12;
        start   = 1'b1;
        cyc();
        for (int c = 1; c <= 12; c++) begin
            abort   = c == 8;
            start   = c == 8;
            tx_data = c == 8 ? 8'h99 : 8'h12;
            @(negedge clk);
            chk("abort+start busy", c, busy, c <= 8);
            chk("abort+start load", c, load, c == 1);
            chk("abort+start done", c, done, 0);
            chk("abort+start pdata", c, pdata, 8'h12);
            chk("abort+start rx", c, rx, 8'h66);
            cyc();
        end
        abort = 1'b0;
        start = 1'b0;
        xfer(8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, '0);
        // reset mid-SHIFT with start held
        tx_data = 8'hF0;
        start   = 1'b1;
        cyc();
        for (int c = 1; c <= 15; c++) begin
            rst_n   = c != 12;
            start   = c == 12;
            tx_data = c == 12 ? 8'h0F : 8'hF0;
            @(negedge clk);
            if (c <= 12) chk("pre-rst busy", c, busy, 1);
            else begin
                chk("mid-rst outputs", c, {load, shift, busy, done}, 0);
                chk("mid-rst rx", c, rx, 0);
                chk("mid-rst pdata", c, pdata, 0);
            end
            cyc();
        end
        rst_n = 1'b1;
        start = 1'b0;
        xfer(8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/shiftreg_sequencer.md
Name: shiftreg_sequencer

Overview:
- Controller that sequences one transfer of the team's parallel-load / serial shift register.
- On a start request it parallel-loads a word, issues WIDTH evenly spaced shift-enable pulses, captures the shift register's parallel output and reports completion.
- Sits between the input conditioners (start/abort come from conditioned edge pulses) and the shift register datapath on the lab FPGA board.

Parameters:
- WIDTH, 8, shift register width and number of shift pulses per transfer (>=1).
- DIV, 4, clock cycles per shift pulse (>=1); DIV=1 means a shift pulse every cycle.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  single-cycle request pulse; honoured only in IDLE.
- abort  input  1  terminates an in-progress transfer.
- tx_data  input  WIDTH  word to load; sampled in the cycle start is accepted.
- sr_pout  input  WIDTH  parallel output of the shift register.
- sr_load  output  1  parallel-load strobe to the shift register.
- sr_pdata  output  WIDTH  parallel-load data to the shift register (latched tx_data).
- sr_shift  output  1  shift-enable pulse (one cycle wide).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- rx_data  output  WIDTH  captured sr_pout from the last completed transfer.

Behaviour:
- States: IDLE, LOAD, SHIFT, FINISH. Counters: div_cnt ($clog2(DIV)+1 bits, 0..DIV-1) and bit_cnt ($clog2(WIDTH)+1 bits, 0..WIDTH).
- Reset (rst_n=0 at a clock edge, in any state): state=IDLE, div_cnt=0, bit_cnt=0, sr_pdata=0, rx_data=0, and all 1-bit outputs 0. Reset in mid-transfer discards the transfer with no done pulse.
- IDLE: if start=1, latch tx_data into sr_pdata and go to LOAD. Otherwise stay in IDLE. abort has no effect in IDLE.
- LOAD (exactly 1 cycle): sr_load=1, then go to SHIFT with div_cnt=0 and bit_cnt=0.
- SHIFT:
  - div_cnt increments every cycle.
  - When div_cnt==DIV-1: sr_shift=1 in that cycle, div_cnt wraps to 0, bit_cnt increments.
  - When the pulse that makes bit_cnt reach WIDTH fires, the next state is FINISH.
  - SHIFT lasts exactly WIDTH*DIV cycles.
- FINISH (1 cycle): at its closing edge, rx_data<=sr_pout, done<=1 and state=IDLE.
- done is registered. It is high for exactly one cycle, the first IDLE cycle after FINISH, with rx_data already valid in that cycle. rx_data holds its value until the next completed transfer.
- sr_load and sr_shift are decoded from state and counters. They are never high in the same cycle and are never high in IDLE or FINISH.
- Timing, with start accepted at the edge ending cycle 0:
  - sr_load is high in cycle 1.
  - sr_shift is high in cycles 1+k*DIV for k=1..WIDTH.
  - FINISH is in cycle 2+WIDTH*DIV.
  - done is high in cycle 3+WIDTH*DIV.
  - busy is high in cycles 1..2+WIDTH*DIV.
- start while busy: ignored, not queued. start in the done cycle (IDLE) is accepted normally, giving back-to-back transfers.
- abort=1 in LOAD, SHIFT or FINISH: next state is IDLE and counters clear. sr_load and sr_shift are suppressed in the abort cycle. No done pulse, and rx_data is unchanged. If abort and start are both high in a busy state, abort wins and start is ignored.
- rst_n has priority over abort and start.

Test Plan:
- Loopback: bench instantiates the team shift register with serial out tied to serial in. WIDTH=8, DIV=4, tx_data=8'hA5, start pulse in cycle 0 -> sr_load in cycle 1; sr_shift in cycles 5,9,...,33 (8 pulses); done in cycle 35 with rx_data=8'hA5; busy high in cycles 1..34.
- Fixed pattern without loopback (serial in held at 0): tx_data=8'hFF, DIV=1 -> sr_shift in cycles 2..9 contiguous; done in cycle 11; rx_data=8'h00.
- start pulses while busy (cycles 10 and 20), then a new start with tx_data=8'h3C in the done cycle -> the busy-time starts are ignored; the second transfer's sr_load rises the cycle after done; loopback rx_data=8'h3C.
- abort in cycle 15 (SHIFT) of a transfer -> busy low in cycle 16, no done, rx_data keeps its previous value; the next transfer completes normally.
- rst_n=0 for 1 cycle mid-SHIFT -> all outputs 0 the cycle after reset, including rx_data=0; start is ignored while rst_n=0.
- abort and start both high in a busy state -> return to IDLE; no new transfer starts until a later start pulse.
